// File: rtl/result_write_arbiter.sv
// rtl/result_write_arbiter.sv - round-robin collector of engine results into frame-RAM writes
// One transaction per engine: ACK (grant pulse), CAP (bus sampled), WR (write strobe).
module result_write_arbiter #(
    parameter int NUM_PROC = 12,
    parameter int H_RES    = 640,
    parameter int V_RES    = 480
) (
    input  logic                clk_iCLK,
    input  logic                iRST_N,
    input  logic [NUM_PROC-1:0] engine_req,
    output logic [NUM_PROC-1:0] req_ack,
    input  logic [26:0]         result_word,
    output logic                wr_en,
    output logic [18:0]         wr_addr,
    output logic [7:0]          wr_data,
    output logic [18:0]         pixel_count,
    output logic                frame_done,
    output logic                range_err
);

    localparam int          IW           = (NUM_PROC > 1) ? $clog2(NUM_PROC) : 1;
    localparam logic [18:0] FRAME_PIXELS = 19'(H_RES * V_RES);

    typedef enum logic [1:0] {IDLE, ACK, CAP, WR} state_t;

    state_t              r_state;
    logic [IW-1:0]       r_last;
    logic                r_wrap_pend;

    logic [NUM_PROC-1:0] w_elig;
    logic [NUM_PROC-1:0] w_grant;
    logic [IW-1:0]       w_idx;
    logic [IW-1:0]       w_win;
    logic                w_found;
    logic [9:0]          w_x;
    logic [8:0]          w_y;
    logic                w_in_range;
    logic [18:0]         w_addr;
    logic [18:0]         w_pix_next;

    assign w_x        = result_word[26:17];
    assign w_y        = result_word[16:8];
    assign w_in_range = (32'(w_x) < 32'(H_RES)) && (32'(w_y) < 32'(V_RES));
    assign w_addr     = 19'(w_x) + 19'(w_y) * 19'(H_RES);
    assign w_pix_next = pixel_count + 19'd1;
    assign w_grant    = NUM_PROC'(1) << w_win;

    // Search starts one past the last grant; the engine just served is skipped while in WR.
    always_comb begin
        w_elig  = engine_req;
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        if (r_state == WR) begin
            w_elig[r_last] = 1'b0;
        end
        for (int k = 1; k <= NUM_PROC; k++) begin
            w_idx = IW'((32'(r_last) + 32'(k)) % 32'(NUM_PROC));
            if (!w_found && w_elig[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    always_ff @(posedge clk_iCLK) begin
        if (!iRST_N) begin
            r_state     <= IDLE;
            r_last      <= IW'(NUM_PROC - 1);
            r_wrap_pend <= 1'b0;
            req_ack     <= '0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            pixel_count <= '0;
            frame_done  <= 1'b0;
            range_err   <= 1'b0;
        end else begin
            frame_done  <= r_wrap_pend;
            r_wrap_pend <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        req_ack <= w_grant;
                        r_last  <= w_win;
                        r_state <= ACK;
                    end
                end
                ACK: begin
                    req_ack <= '0;
                    r_state <= CAP;
                end
                CAP: begin
                    r_state <= WR;
                    if (w_in_range) begin
                        wr_en   <= 1'b1;
                        wr_addr <= w_addr;
                        wr_data <= result_word[7:0];
                        if (w_pix_next == FRAME_PIXELS) begin
                            pixel_count <= '0;
                            r_wrap_pend <= 1'b1;
                        end else begin
                            pixel_count <= w_pix_next;
                        end
                    end else begin
                        range_err <= 1'b1;
                    end
                end
                WR: begin
                    wr_en <= 1'b0;
                    if (w_found) begin
                        req_ack <= w_grant;
                        r_last  <= w_win;
                        r_state <= ACK;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_result_write_arbiter.sv
// tb/tb_result_write_arbiter.sv - self-checking bench for result_write_arbiter
// Full-size instance plus a 10x6 instance so frame wrap fits in a short run.
module tb_result_write_arbiter;

    localparam int N = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n       = 1'b0;
    logic [N-1:0]  engine_req  = '0;
    logic [26:0]   result_word = '0;

    logic [N-1:0]  d_ack, s_ack;
    logic          d_wr, s_wr, d_fd, s_fd, d_re, s_re;
    logic [18:0]   d_addr, s_addr, d_pc, s_pc;
    logic [7:0]    d_data, s_data;

    result_write_arbiter #(.NUM_PROC(N), .H_RES(640), .V_RES(480)) u_full (
        .clk_iCLK(clk), .iRST_N(rst_n), .engine_req(engine_req), .req_ack(d_ack),
        .result_word(result_word), .wr_en(d_wr), .wr_addr(d_addr), .wr_data(d_data),
        .pixel_count(d_pc), .frame_done(d_fd), .range_err(d_re)
    );

    result_write_arbiter #(.NUM_PROC(N), .H_RES(10), .V_RES(6)) u_small (
        .clk_iCLK(clk), .iRST_N(rst_n), .engine_req(engine_req), .req_ack(s_ack),
        .result_word(result_word), .wr_en(s_wr), .wr_addr(s_addr), .wr_data(s_data),
        .pixel_count(s_pc), .frame_done(s_fd), .range_err(s_re)
    );

    bit            sel = 1'b0;
    int            hres, vres;
    logic [N-1:0]  o_ack;
    logic          o_wr, o_fd, o_re;
    logic [18:0]   o_addr, o_pc;
    logic [7:0]    o_data;

    assign hres   = sel ? 10 : 640;
    assign vres   = sel ? 6 : 480;
    assign o_ack  = sel ? s_ack : d_ack;
    assign o_wr   = sel ? s_wr : d_wr;
    assign o_fd   = sel ? s_fd : d_fd;
    assign o_re   = sel ? s_re : d_re;
    assign o_addr = sel ? s_addr : d_addr;
    assign o_pc   = sel ? s_pc : d_pc;
    assign o_data = sel ? s_data : d_data;

    int n_pass = 0;
    int n_tot  = 0;
    int cyc    = 0;

    // stimulus state
    logic [N-1:0] held     = '0;
    bit           rst_drv  = 1'b0;
    bit           keep_req = 1'b0;
    bit           rand_req = 1'b0;
    bit           rand_wd  = 1'b0;
    logic [26:0]  dir_word = '0;

    // reference model state
    int           mlast    = N - 1;
    bit           have_ack = 1'b0;
    int           last_ack = 0;
    int           pc_m     = 0;
    bit           rerr_m   = 1'b0;
    bit           fd_pend  = 1'b0;
    logic [26:0]  txn_word = '0;
    int           fd_seen  = 0;
    int           fd_exp   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    endtask

    function automatic logic [26:0] make_word();
        int x, y;
        if (!rand_wd) return dir_word;
        x = $urandom_range(0, hres + 1);
        y = $urandom_range(0, vres + 1);
        return {10'(x), 9'(y), 8'($urandom_range(0, 255))};
    endfunction

    // Transaction-level model: grant = nearest requester after the previous grant,
    // decided one cycle before the ack; write lands two cycles after the ack.
    task automatic check_cycle();
        logic [N-1:0] elig;
        logic [N-1:0] exp_ack;
        bit           exp_wr, exp_fd;
        int           x, y, w;
        if (!rst_n) begin
            mlast = N - 1; have_ack = 1'b0; pc_m = 0; rerr_m = 1'b0; fd_pend = 1'b0;
            chk("rst_ack", 32'(o_ack), 0);
            chk("rst_wr_en", 32'(o_wr), 0);
            chk("rst_wr_addr", 32'(o_addr), 0);
            chk("rst_wr_data", 32'(o_data), 0);
            chk("rst_pixel_count", 32'(o_pc), 0);
            chk("rst_frame_done", 32'(o_fd), 0);
            chk("rst_range_err", 32'(o_re), 0);
            return;
        end
        exp_fd  = fd_pend;
        fd_pend = 1'b0;
        exp_wr  = 1'b0;
        if (have_ack && cyc == last_ack + 2) begin
            x = int'(txn_word[26:17]);
            y = int'(txn_word[16:8]);
            if (x < hres && y < vres) begin
                exp_wr = 1'b1;
                chk("wr_addr", 32'(o_addr), 32'(x + y * hres));
                chk("wr_data", 32'(o_data), 32'(txn_word[7:0]));
                pc_m++;
                if (pc_m == hres * vres) begin
                    pc_m = 0; fd_pend = 1'b1; fd_exp++;
                end
            end else begin
                rerr_m = 1'b1;
            end
        end
        exp_ack = '0;
        if (!have_ack || cyc >= last_ack + 3) begin
            elig = engine_req;
            if (have_ack && cyc == last_ack + 3) elig[mlast] = 1'b0;
            w = -1;
            for (int k = 1; k <= N; k++)
                if (w < 0 && elig[(mlast + k) % N]) w = (mlast + k) % N;
            if (w >= 0) begin
                exp_ack[w] = 1'b1; mlast = w; last_ack = cyc; have_ack = 1'b1;
            end
        end
        if (o_fd) fd_seen++;
        chk("req_ack", 32'(o_ack), 32'(exp_ack));
        chk("wr_en", 32'(o_wr), 32'(exp_wr));
        chk("pixel_count", 32'(o_pc), 32'(pc_m));
        chk("frame_done", 32'(o_fd), 32'(exp_fd));
        chk("range_err", 32'(o_re), 32'(rerr_m));
    endtask

    task automatic drive();
        rst_n = rst_drv;
        if (o_ack != '0) begin
            txn_word    = make_word();
            result_word = txn_word;
            if (!keep_req) held = held & ~o_ack;
        end
        if (rand_req)
            for (int i = 0; i < N; i++)
                if (!held[i] && $urandom_range(0, 3) == 0) held[i] = 1'b1;
        engine_req = held;
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        check_cycle();
        drive();
    endtask

    task automatic wait_ack(input string tag);
        bit found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (o_ack != '0) found = 1'b1;
        end
        chk(tag, 32'(found), 1);
    endtask

    initial begin
        int g[$];
        int idx;
        logic [N-1:0] seen;

        repeat (3) step();
        rst_drv = 1'b1;
        step();

        // single request, address 5 + 2*640
        dir_word = {10'd5, 9'd2, 8'h3C};
        held     = 12'h004;
        wait_ack("r31_ack_seen");
        chk("r31_ack", 32'(o_ack), 32'h004);
        step();
        chk("r31_ack_one_cycle", 32'(o_ack), 0);
        step();
        chk("r31_wr_en", 32'(o_wr), 1);
        chk("r31_wr_addr", 32'(o_addr), 1285);
        chk("r31_wr_data", 32'(o_data), 32'h3C);
        chk("r31_pixel_count", 32'(o_pc), 1);

        // corner address
        dir_word = {10'd639, 9'd479, 8'hAA};
        held[7]  = 1'b1;
        wait_ack("r35_ack_seen");
        step(); step();
        chk("r35_wr_addr", 32'(o_addr), 307199);
        chk("r35_pixel_count", 32'(o_pc), 2);

        // out-of-range x then y
        dir_word = {10'd640, 9'd0, 8'h11};
        held[1]  = 1'b1;
        wait_ack("r33a_ack_seen");
        step(); step();
        chk("r33a_wr_en", 32'(o_wr), 0);
        chk("r33a_range_err", 32'(o_re), 1);
        chk("r33a_pixel_count", 32'(o_pc), 2);
        dir_word = {10'd0, 9'd480, 8'h22};
        held[1]  = 1'b1;
        wait_ack("r33b_ack_seen");
        step(); step();
        chk("r33b_wr_en", 32'(o_wr), 0);
        repeat (5) step();
        chk("r33b_range_err_sticky", 32'(o_re), 1);
        chk("r33b_pixel_count", 32'(o_pc), 2);

        // fairness with every engine requesting continuously
        rst_drv = 1'b0; step(); step();
        rst_drv = 1'b1; rand_wd = 1'b1; keep_req = 1'b1; held = '1;
        for (int i = 0; i < 60 && g.size() < 13; i++) begin
            step();
            if (o_ack != '0) begin
                idx = -1;
                for (int b = 0; b < N; b++) if (o_ack[b]) idx = b;
                g.push_back(idx);
            end
        end
        keep_req = 1'b0; held = '0;
        chk("fair_grant_count", 32'(g.size()), 13);
        for (int k = 0; k < g.size(); k++) chk("fair_order", 32'(g[k]), 32'(k % N));
        for (int k = 0; k + N <= g.size(); k++) begin
            seen = '0;
            for (int j = 0; j < N; j++) if (g[k + j] >= 0) seen[g[k + j]] = 1'b1;
            chk("fair_window_distinct", 32'(seen), 32'hFFF);
        end
        repeat (6) step();

        // reset during CAP abandons the write
        rand_wd  = 1'b0;
        dir_word = {10'd3, 9'd3, 8'h55};
        held     = 12'h008;
        wait_ack("r36_ack_seen");
        rst_drv = 1'b0;
        step();
        step();
        chk("r36_no_wr", 32'(o_wr), 0);
        chk("r36_pixel_count", 32'(o_pc), 0);
        held    = 12'h228;
        rst_drv = 1'b1;
        wait_ack("r36_regrant_seen");
        chk("r36_first_grant", 32'(o_ack), 32'h008);
        held = '0;

        // randomized traffic on the full-size instance
        rand_req = 1'b1; rand_wd = 1'b1;
        repeat (600) step();
        rand_req = 1'b0; held = '0;
        repeat (10) step();

        // switch to the small frame under reset and run until several wraps
        rst_drv = 1'b0; step(); step();
        sel = 1'b1; fd_seen = 0; fd_exp = 0;
        step();
        rst_drv = 1'b1; rand_req = 1'b1;
        repeat (1200) step();
        rand_req = 1'b0; held = '0;
        repeat (20) step();
        chk("frame_done_total", 32'(fd_seen), 32'(fd_exp));
        chk("frame_done_seen", 32'(fd_seen > 0), 1);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/result_write_arbiter.md
RESULT_WRITE_ARBITER -- requirements
Module: result_write_arbiter

Interface
REQ-001 SHALL have parameter NUM_PROC, default 12, number of calculating engines served.
REQ-002 SHALL have parameter H_RES, default 640, frame width in pixels.
REQ-003 SHALL have parameter V_RES, default 480, frame height in pixels.
REQ-004 SHALL have port clk_iCLK  input  1  engine clock; the only clock.
REQ-005 SHALL have port iRST_N  input  1  reset; synchronous, active-low.
REQ-006 SHALL have port engine_req  input  NUM_PROC  per-engine service request; level, held until acked.
REQ-007 SHALL have port req_ack  output  NUM_PROC  one-hot grant pulse to the selected engine.
REQ-008 SHALL have port result_word  input  27  shared engine bus: [26:17] x, [16:8] y, [7:0] iteration count.
REQ-009 SHALL have port wr_en  output  1  frame-RAM write strobe.
REQ-010 SHALL have port wr_addr  output  19  frame-RAM address.
REQ-011 SHALL have port wr_data  output  8  frame-RAM data (iteration count).
REQ-012 SHALL have port pixel_count  output  19  pixels written in the current frame.
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse at frame completion.
REQ-014 SHALL have port range_err  output  1  sticky flag; an out-of-range coordinate was received.

Function
REQ-015 SHALL implement FSM states IDLE, ACK, CAP, WR; all outputs registered.
REQ-016 IDLE: if any engine_req bit set, select a winner and go to ACK; else stay in IDLE.
REQ-017 ACK: req_ack = one-hot of winner for exactly this cycle; next state CAP.
REQ-018 CAP: req_ack = 0; result_word sampled at the end of this cycle; next state WR.
REQ-019 WR: wr_en = 1 for exactly one cycle with wr_addr/wr_data from the CAP sample; if any eligible request is pending, select a winner and go to ACK, else go to IDLE.
REQ-020 Latency: request seen in IDLE at cycle T -> req_ack at T+1 -> sample at T+2 -> wr_en at T+3; back-to-back service every 3 cycles.
REQ-021 Arbitration SHALL be round-robin: search starts at last-granted index +1, wrapping from NUM_PROC-1 to 0; reset value of last-granted index is NUM_PROC-1 (engine 0 wins first).
REQ-022 The engine granted in the current transaction SHALL be ineligible for selection in the WR cycle of that transaction.
REQ-023 wr_addr SHALL equal x + y*H_RES, computed at 19 bits without truncation; wr_data = result_word[7:0].
REQ-024 If x >= H_RES or y >= V_RES, WR SHALL keep wr_en = 0, set range_err, and leave pixel_count unchanged; the transaction still completes (engine acked).
REQ-025 pixel_count SHALL increment by 1 on each wr_en cycle.
REQ-026 When a write brings pixel_count to H_RES*V_RES, pixel_count SHALL become 0 and frame_done SHALL pulse high in the following cycle.
REQ-027 range_err SHALL clear only on reset.
REQ-028 Requests arriving in ACK or CAP SHALL be held pending, never lost, provided the engine keeps its request asserted.

Reset
REQ-029 While iRST_N = 0 at a clock edge: state = IDLE, req_ack = 0, wr_en = 0, wr_addr = 0, wr_data = 0, pixel_count = 0, frame_done = 0, range_err = 0, last-granted = NUM_PROC-1.
REQ-030 Reset asserted mid-transaction SHALL abandon the transaction with no write issued; the engine re-requests afterwards.

Verification
REQ-031 Single request: engine_req = 12'h004, bus x=5 y=2 iter=8'h3C -> req_ack = 12'h004 one cycle, wr_en 2 cycles later with wr_addr = 1285, wr_data = 8'h3C, pixel_count = 1.
REQ-032 Fairness: all 12 requests held continuously -> acks in order 0,1,...,11,0; no engine granted twice in any 12 consecutive grants.
REQ-033 Range: x=640 y=0, then x=0 y=480 -> no wr_en, range_err = 1 and stays 1, pixel_count unchanged.
REQ-034 Frame wrap: 307200 in-range writes -> pixel_count returns to 0 and frame_done pulses once, one cycle after the final wr_en.
REQ-035 Corner address: x=639 y=479 -> wr_addr = 307199.
REQ-036 Mid-operation reset: iRST_N = 0 during CAP -> no wr_en; all outputs at reset values; first post-reset grant goes to lowest-index requester.
